// File: rtl/dram_check_pkg.sv
// Shared definitions for the DRAM pattern checker.
//   state_e      : checker FSM states
//   LFSR_POLY    : Galois feedback mask of the 32-bit test-pattern LFSR
//   lfsr_next()  : one LFSR step
package dram_check_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_GO,
        WR_FILL,
        WR_WAIT,
        RD_GO,
        RD_DRAIN,
        DONE
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/dram_pattern_checker_if.sv
// Control/user bus between the pattern checker and the Avalon-MM
// write-master / read-master subsystem.
//   master modport : checker side (drives go, base/length, buffer strobes, write data)
//   slave modport  : master-subsystem side (drives done, full, read data, available)
interface dram_pattern_checker_if #(
    parameter int ADDRESSWIDTH = 28
);
    logic                    write_control_fixed_location;
    logic [ADDRESSWIDTH-1:0] write_control_write_base;
    logic [ADDRESSWIDTH-1:0] write_control_write_length;
    logic                    write_control_go;
    logic                    write_control_done;
    logic                    write_user_write_buffer;
    logic [31:0]             write_user_buffer_data;
    logic                    write_user_buffer_full;

    logic                    read_control_fixed_location;
    logic [ADDRESSWIDTH-1:0] read_control_read_base;
    logic [ADDRESSWIDTH-1:0] read_control_read_length;
    logic                    read_control_go;
    logic                    read_control_done;
    logic                    read_user_read_buffer;
    logic [31:0]             read_user_buffer_output_data;
    logic                    read_user_data_available;

    modport master (
        output write_control_fixed_location, write_control_write_base,
               write_control_write_length, write_control_go,
               write_user_write_buffer, write_user_buffer_data,
               read_control_fixed_location, read_control_read_base,
               read_control_read_length, read_control_go,
               read_user_read_buffer,
        input  write_control_done, write_user_buffer_full,
               read_control_done, read_user_buffer_output_data,
               read_user_data_available
    );

    modport slave (
        input  write_control_fixed_location, write_control_write_base,
               write_control_write_length, write_control_go,
               write_user_write_buffer, write_user_buffer_data,
               read_control_fixed_location, read_control_read_base,
               read_control_read_length, read_control_go,
               read_user_read_buffer,
        output write_control_done, write_user_buffer_full,
               read_control_done, read_user_buffer_output_data,
               read_user_data_available
    );

endinterface

// File: rtl/dram_check_lfsr.sv
// 32-bit Galois LFSR register for the test pattern.
//   clk, reset_n : clock, async active-low reset (register resets to 1)
//   load_i       : load load_val_i (has priority over advance_i)
//   advance_i    : step the LFSR once
//   value_o      : current LFSR value
module dram_check_lfsr
    import dram_check_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [31:0] load_val_i,
    input  logic        advance_i,
    output logic [31:0] value_o
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = load_val_i;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q <= 32'd1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/dram_pattern_checker.sv
// DRAM pattern checker: fills [base, base+length) with a seeded LFSR sequence
// through the write master, reads it back through the read master and
// compares every word against a regenerated copy of the sequence.
//   clk, reset_n        : clock, async active-low reset
//   start               : begin a test (ignored while busy)
//   base, length, seed  : byte base, byte length, LFSR seed (0 -> 1), sampled at start
//   inject_err          : only with DRAM_CHECK_INJECT_EN; flips bit 0 of the first written word
//   busy, done, pass    : status; done pulses once at the end of a test
//   error_count         : mismatching words (saturating)
//   first_err_addr      : byte address of the first mismatch, 0 if none
//   avm                 : control/user bus to the Avalon-MM master subsystem
// Optional feature macro: DRAM_CHECK_INJECT_EN
module dram_pattern_checker
    import dram_check_pkg::*;
#(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDRESSWIDTH-1:0] base,
    input  logic [ADDRESSWIDTH-1:0] length,
    input  logic [31:0]             seed,
`ifdef DRAM_CHECK_INJECT_EN
    input  logic                    inject_err,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [15:0]             error_count,
    output logic [ADDRESSWIDTH-1:0] first_err_addr,
    dram_pattern_checker_if.master  avm
);

    localparam logic [ADDRESSWIDTH-1:0] A_ONE  = ADDRESSWIDTH'(1);
    localparam logic [ADDRESSWIDTH-1:0] A_FOUR = ADDRESSWIDTH'(4);

    state_e                  state_q;
    logic [ADDRESSWIDTH-1:0] base_q, length_q, remaining_q, rd_addr_q, first_err_q;
    logic [31:0]             seed_q;
    logic [15:0]             err_cnt_q;
    logic                    busy_q, done_q, pass_q, rd_done_seen_q;

    logic [ADDRESSWIDTH-1:0] n_words, n_start;
    logic [31:0]             seed_eff;
    logic                    wr_fire, rd_fire, mismatch;
    logic                    lfsr_load;
    logic [31:0]             lfsr_load_val;
    logic [DATAWIDTH-1:0]    lfsr_val;
    logic [31:0]             wr_data;

    assign n_words  = length_q >> 2;
    assign n_start  = length >> 2;
    assign seed_eff = (seed == 32'd0) ? 32'd1 : seed;

    // Buffer strobes must react to full/available within the same cycle,
    // so they are decoded combinationally from registered state.
    assign wr_fire  = (state_q == WR_FILL) && !avm.write_user_buffer_full && (remaining_q != '0);
    assign rd_fire  = (state_q == RD_DRAIN) && avm.read_user_data_available && (remaining_q != '0);
    assign mismatch = rd_fire && (avm.read_user_buffer_output_data != lfsr_val);

    assign lfsr_load     = ((state_q == IDLE) && start) ||
                           ((state_q == WR_WAIT) && avm.write_control_done);
    assign lfsr_load_val = (state_q == IDLE) ? seed_eff : seed_q;

    dram_check_lfsr u_lfsr (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (lfsr_load),
        .load_val_i (lfsr_load_val),
        .advance_i  (wr_fire || rd_fire),
        .value_o    (lfsr_val)
    );

`ifdef DRAM_CHECK_INJECT_EN
    logic inject_q;
    // The first word is the one written while remaining still equals N.
    assign wr_data = lfsr_val ^ {31'd0, inject_q && (remaining_q == n_words)};
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inject_q <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            inject_q <= inject_err;
        end
    end
`else
    assign wr_data = lfsr_val;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            base_q         <= '0;
            length_q       <= '0;
            seed_q         <= '0;
            remaining_q    <= '0;
            rd_addr_q      <= '0;
            first_err_q    <= '0;
            err_cnt_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            rd_done_seen_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q      <= base;
                        length_q    <= length;
                        seed_q      <= seed_eff;
                        remaining_q <= n_start;
                        err_cnt_q   <= '0;
                        first_err_q <= '0;
                        if (n_start == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            pass_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= WR_GO;
                            pass_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                WR_GO: state_q <= WR_FILL;
                WR_FILL: begin
                    if (wr_fire) begin
                        remaining_q <= remaining_q - A_ONE;
                        if (remaining_q == A_ONE) state_q <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (avm.write_control_done) state_q <= RD_GO;
                end
                RD_GO: begin
                    remaining_q    <= n_words;
                    rd_addr_q      <= base_q;
                    rd_done_seen_q <= 1'b0;
                    state_q        <= RD_DRAIN;
                end
                RD_DRAIN: begin
                    if (avm.read_control_done) rd_done_seen_q <= 1'b1;
                    if (rd_fire) begin
                        remaining_q <= remaining_q - A_ONE;
                        rd_addr_q   <= rd_addr_q + A_FOUR;
                        if (mismatch) begin
                            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
                            if (err_cnt_q == 16'd0)    first_err_q <= rd_addr_q;
                        end
                    end
                    // No read can fire once remaining is 0, so err_cnt_q is final here.
                    if ((remaining_q == '0) && (rd_done_seen_q || avm.read_control_done)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_cnt_q == 16'd0);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign error_count    = err_cnt_q;
    assign first_err_addr = first_err_q;

    assign avm.write_control_fixed_location = 1'b0;
    assign avm.write_control_write_base     = base_q;
    assign avm.write_control_write_length   = length_q;
    assign avm.write_control_go             = (state_q == WR_GO);
    assign avm.write_user_write_buffer      = wr_fire;
    assign avm.write_user_buffer_data       = wr_data;

    assign avm.read_control_fixed_location  = 1'b0;
    assign avm.read_control_read_base       = base_q;
    assign avm.read_control_read_length     = length_q;
    assign avm.read_control_go              = (state_q == RD_GO);
    assign avm.read_user_read_buffer        = rd_fire;

endmodule

// File: tb/tb_dram_pattern_checker.sv
// Self-checking bench for dram_pattern_checker with a behavioural memory /
// master-subsystem model on the slave side of the bus.
module tb_dram_pattern_checker;

    localparam int AW = 28;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [AW-1:0] length = '0;
    logic [31:0]   seed = '0;
`ifdef DRAM_CHECK_INJECT_EN
    logic          inject_err = 1'b0;
`endif
    logic          busy, done, pass;
    logic [15:0]   error_count;
    logic [AW-1:0] first_err_addr;

    dram_pattern_checker_if #(.ADDRESSWIDTH(AW)) bus ();

    dram_pattern_checker #(.ADDRESSWIDTH(AW), .DATAWIDTH(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base           (base),
        .length         (length),
        .seed           (seed),
`ifdef DRAM_CHECK_INJECT_EN
        .inject_err     (inject_err),
`endif
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .error_count    (error_count),
        .first_err_addr (first_err_addr),
        .avm            (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // ---------------- slave-side model ----------------
    int          cyc = 0;
    bit          full_mode = 0, gap_mode = 0, rd_done_early = 0;
    logic [63:0] corrupt_mask = '0;
    logic [31:0] mem [int];
    logic [31:0] rq [$];
    logic [31:0] wr_log [$];
    int          wgo_cnt = 0, rgo_cnt = 0, wr_strobes = 0, rd_strobes = 0, viol = 0;
    int          first_wr_cyc = -1, last_wr_cyc = -1, first_rd_cyc = -1, last_rd_cyc = -1;
    int          wr_ptr = 0, wr_words = 0, rd_words = 0;
    bit          wdone_pend = 0, rdone_pend = 0;

    // Inputs change at the falling edge; strobes are sampled 1 time unit later,
    // which is the value the DUT consumes at the next rising edge.
    initial begin
        int          a;
        logic [31:0] w;
        bus.write_control_done           = 1'b0;
        bus.write_user_buffer_full       = 1'b0;
        bus.read_control_done            = 1'b0;
        bus.read_user_buffer_output_data = '0;
        bus.read_user_data_available     = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            bus.write_control_done           = wdone_pend;
            wdone_pend                       = 1'b0;
            bus.read_control_done            = rdone_pend;
            rdone_pend                       = 1'b0;
            bus.write_user_buffer_full       = full_mode && cyc[0];
            bus.read_user_data_available     = (rq.size() != 0) && !(gap_mode && (cyc % 3 == 0));
            bus.read_user_buffer_output_data = (rq.size() != 0) ? rq[0] : 32'hDEAD_BEEF;
            #1;
            if (bus.write_control_go) begin
                wgo_cnt++;
                wr_ptr   = int'(bus.write_control_write_base);
                wr_words = int'(bus.write_control_write_length >> 2);
            end
            if (bus.write_user_write_buffer) begin
                if (bus.write_user_buffer_full) viol++;
                mem[wr_ptr] = bus.write_user_buffer_data;
                wr_ptr += 4;
                wr_log.push_back(bus.write_user_buffer_data);
                wr_strobes++;
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                if (wr_strobes == wr_words) wdone_pend = 1'b1;
            end
            if (bus.read_control_go) begin
                rgo_cnt++;
                rq.delete();
                rd_words = int'(bus.read_control_read_length >> 2);
                for (int i = 0; i < rd_words; i++) begin
                    a = int'(bus.read_control_read_base) + 4 * i;
                    w = mem.exists(a) ? mem[a] : 32'h0;
                    if (i < 64 && corrupt_mask[i]) w = w ^ 32'h0000_0100;
                    rq.push_back(w);
                end
                if (rd_done_early) rdone_pend = 1'b1;
            end
            if (bus.read_user_read_buffer) begin
                rd_strobes++;
                if (!bus.read_user_data_available || rq.size() == 0) viol++;
                else void'(rq.pop_front());
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                last_rd_cyc = cyc;
                if (rd_strobes == rd_words && !rd_done_early) rdone_pend = 1'b1;
            end
        end
    end

    function automatic logic [31:0] ref_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] length;
        logic [31:0]   seed;
        logic [63:0]   mask;
        bit            full_m;
        bit            gap_m;
        bit            early;
        bit            exp_pass;
        logic [15:0]   exp_err;
        logic [AW-1:0] exp_first;
    } vec_t;

    vec_t vecs [5];

    task automatic model_clear(input vec_t v);
        full_mode     = v.full_m;
        gap_mode      = v.gap_m;
        rd_done_early = v.early;
        corrupt_mask  = v.mask;
        wgo_cnt = 0; rgo_cnt = 0; wr_strobes = 0; rd_strobes = 0; viol = 0;
        first_wr_cyc = -1; last_wr_cyc = -1; first_rd_cyc = -1; last_rd_cyc = -1;
        wr_log.delete();
    endtask

    task automatic run_vec(input vec_t v, input bit inj);
        int          n, start_cyc, bad;
        bit          got;
        logic [31:0] x, e;
        n = int'(v.length >> 2);
        step();
        model_clear(v);
        base   = v.base;
        length = v.length;
        seed   = v.seed;
`ifdef DRAM_CHECK_INJECT_EN
        inject_err = inj;
`endif
        start     = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("status_cleared_at_start", {pass, error_count, first_err_addr}, 0);
        got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            if (c == 2) start = 1'b1;   // must be ignored while busy
            if (c == 3) start = 1'b0;
            step();
            if (done) got = 1;
        end
        check("done_within_budget", got, 1);
        if (got) begin
            check("pass", pass, v.exp_pass);
            check("error_count", error_count, v.exp_err);
            check("first_err_addr", first_err_addr, v.exp_first);
            check("busy_low_with_done", busy, 0);
            start = 1'b1;               // same cycle as done: must be ignored
            step();
            start = 1'b0;
            check("start_at_done_ignored", busy, 0);
            check("done_single_pulse", done, 0);
            check("write_go_count", wgo_cnt, 1);
            check("read_go_count", rgo_cnt, 1);
            check("write_strobes", wr_strobes, n);
            check("read_strobes", rd_strobes, n);
            check("strobe_violations", viol, 0);
            bad = 0;
            x = (v.seed == 32'd0) ? 32'd1 : v.seed;
            for (int i = 0; i < n && i < wr_log.size(); i++) begin
                e = x;
                if (inj && i == 0) e[0] = ~e[0];
                if (wr_log[i] !== e) bad++;
                x = ref_step(x);
            end
            check("write_data_words_wrong", bad, 0);
            if (!v.full_m) begin
                check("first_write_latency", first_wr_cyc - start_cyc, 2);
                check("write_throughput", last_wr_cyc - first_wr_cyc, n - 1);
            end
            if (!v.gap_m) check("read_throughput", last_rd_cyc - first_rd_cyc, n - 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_status"}, {busy, done, pass, error_count, first_err_addr}, 0);
        check({tag, "_bus"}, {bus.write_control_go, bus.read_control_go,
                              bus.write_user_write_buffer, bus.read_user_read_buffer,
                              bus.write_control_fixed_location, bus.read_control_fixed_location,
                              bus.write_control_write_base, bus.read_control_read_length}, 0);
    endtask

    initial begin
        vec_t        v;
        int          k;
        logic [31:0] seq4 [4];
        seq4 = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};
        //            base          length  seed          mask        full gap early pass err    first
        vecs[0] = '{28'h000_0100, 28'd16,  32'h0000_0001, 64'h0,      0,   0,  0,    1,   16'd0, 28'h0};
        vecs[1] = '{28'h000_0100, 28'd16,  32'h0000_0001, 64'h4,      0,   0,  0,    0,   16'd1, 28'h000_0108};
        vecs[2] = '{28'h000_2000, 28'd256, 32'h1234_5678, 64'h0,      1,   1,  0,    1,   16'd0, 28'h0};
        vecs[3] = '{28'h000_0040, 28'd32,  32'h0000_0000, 64'h81,     0,   0,  1,    0,   16'd2, 28'h000_0040};
        vecs[4] = '{28'hFFF_FFC0, 28'd64,  32'hDEAD_BEEF, 64'h8000,   1,   0,  1,    0,   16'd1, 28'hFFF_FFFC};

        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], 1'b0);
            if (i == 0) begin
                for (int j = 0; j < 4; j++)
                    check("seed1_sequence", (wr_log.size() > j) ? wr_log[j] : 32'hX, seq4[j]);
            end
        end

        // Zero-length region: done the cycle after start, no go pulses.
        step();
        model_clear(vecs[0]);
        base = 28'h700; length = '0; seed = 32'h5; start = 1'b1;
        step();
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_pass", pass, 1);
        check("len0_busy", busy, 0);
        check("len0_status", {error_count, first_err_addr}, 0);
        step();
        check("len0_done_pulse", done, 0);
        step();
        check("len0_go_pulses", wgo_cnt + rgo_cnt, 0);

        // Reset in the middle of the write fill.
        v = '{28'h000_0300, 28'd64, 32'h0000_0007, 64'h0, 0, 0, 0, 1, 16'd0, 28'h0};
        step();
        model_clear(v);
        base = v.base; length = v.length; seed = v.seed; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 50 && wr_strobes < 3; c++) step();
        check("reached_wr_fill", wr_strobes >= 3, 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        k = wr_strobes;
        repeat (3) step();
        check("no_strobes_in_reset", wr_strobes + rd_strobes + rgo_cnt, k + 0 + 0);
        reset_n = 1'b1;
        run_vec(v, 1'b0);

`ifdef DRAM_CHECK_INJECT_EN
        v = '{28'h000_0500, 28'd16, 32'h0000_0000, 64'h0, 0, 0, 0, 0, 16'd1, 28'h000_0500};
        run_vec(v, 1'b1);
        check("inject_first_word", (wr_log.size() > 0) ? wr_log[0] : 32'hX, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
